scbuf_rdrtn_err_ctl: RTL

- Sits in scbuf at the far end of the sctag-to-scbuf repeater path.
- Consumes the repeated evict-read and RDMA-read controls and the data-array ECC check results.
- Produces the error-return strobes back to sctag: scbuf_sctag_ev_uerr_r5/cerr_r5 once per completed 8-dword eviction, and scbuf_sctag_rdma_uerr_c10/cerr_c10 once per RDMA read.
- Checks evict dword sequencing and flags protocol violations.

---
 rtl/scbuf_rdrtn_err_ctl_pkg.sv | 22 ++
 rtl/scbuf_rdrtn_err_ctl_if.sv | 36 +++
 rtl/scbuf_err_dly.sv | 30 +++
 rtl/scbuf_rdrtn_err_ctl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/scbuf_rdrtn_err_ctl_pkg.sv
// Shared constants, FSM encoding and error-resolution helper for the
// scbuf read-return error control slice.
package scbuf_pkg;

  localparam int unsigned DEF_ECC_LAT      = 3;
  localparam int unsigned DEF_EV_RPT_LAT   = 5;
  localparam int unsigned DEF_RDMA_RPT_LAT = 7;
  localparam int unsigned EV_DWORDS        = 8;
  localparam int unsigned EV_DW_W          = 3;
  localparam logic [EV_DW_W-1:0] EV_LAST_DW = EV_DW_W'(EV_DWORDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } ev_state_e;

  // Reported {uerr, cerr}: a UE masks any CE on the same report.
  function automatic logic [1:0] err_resolve(input logic u, input logic c);
    return {u, c & ~u};
  endfunction

endpackage

// File: rtl/scbuf_rdrtn_err_ctl_if.sv
// Control/ECC inputs and error-return outputs of the read-return error block.
interface scbuf_rdrtn_err_ctl_if;
  logic       sctag_scbuf_evict_en_r0;
  logic [2:0] sctag_scbuf_ev_dword_r0;
  logic       sctag_scbuf_rdma_rden_r0;
  logic [1:0] sctag_scbuf_rdma_rdwl_r0;
  logic       ecc_ev_uerr_r3;
  logic       ecc_ev_cerr_r3;
  logic       ecc_rdma_uerr_r3;
  logic       ecc_rdma_cerr_r3;
  logic       scbuf_sctag_ev_uerr_r5;
  logic       scbuf_sctag_ev_cerr_r5;
  logic       scbuf_sctag_rdma_uerr_c10;
  logic       scbuf_sctag_rdma_cerr_c10;
  logic [1:0] scbuf_rdma_err_wl_c10;
  logic       ev_seq_err;
  logic       ev_busy;

  modport master (
    output sctag_scbuf_evict_en_r0, sctag_scbuf_ev_dword_r0,
           sctag_scbuf_rdma_rden_r0, sctag_scbuf_rdma_rdwl_r0,
           ecc_ev_uerr_r3, ecc_ev_cerr_r3, ecc_rdma_uerr_r3, ecc_rdma_cerr_r3,
    input  scbuf_sctag_ev_uerr_r5, scbuf_sctag_ev_cerr_r5,
           scbuf_sctag_rdma_uerr_c10, scbuf_sctag_rdma_cerr_c10,
           scbuf_rdma_err_wl_c10, ev_seq_err, ev_busy
  );

  modport slave (
    input  sctag_scbuf_evict_en_r0, sctag_scbuf_ev_dword_r0,
           sctag_scbuf_rdma_rden_r0, sctag_scbuf_rdma_rdwl_r0,
           ecc_ev_uerr_r3, ecc_ev_cerr_r3, ecc_rdma_uerr_r3, ecc_rdma_cerr_r3,
    output scbuf_sctag_ev_uerr_r5, scbuf_sctag_ev_cerr_r5,
           scbuf_sctag_rdma_uerr_c10, scbuf_sctag_rdma_cerr_c10,
           scbuf_rdma_err_wl_c10, ev_seq_err, ev_busy
  );
endinterface

// File: rtl/scbuf_err_dly.sv
// N-stage delay line, cleared to zero by reset; DEPTH = 0 is a wire.
module scbuf_err_dly #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift register; reset flushes every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/scbuf_rdrtn_err_ctl.sv
// Read-return error control: aggregates data-array ECC results per 8-dword
// eviction and per RDMA read, and returns timed error strobes to sctag.
module scbuf_rdrtn_err_ctl
  import scbuf_pkg::*;
#(
  parameter int unsigned ECC_LAT      = DEF_ECC_LAT,
  parameter int unsigned EV_RPT_LAT   = DEF_EV_RPT_LAT,
  parameter int unsigned RDMA_RPT_LAT = DEF_RDMA_RPT_LAT
) (
  input logic                  rclk,
  input logic                  arst_l,
  scbuf_rdrtn_err_ctl_if.slave bus
);

  // ---------------- evict stream ----------------
  logic [EV_DW_W:0]   ev_pipe_r3;
  logic               ev_vld_r3;
  logic [EV_DW_W-1:0] ev_dword_r3;

  scbuf_err_dly #(.WIDTH(EV_DW_W + 1), .DEPTH(ECC_LAT)) u_ev_r3_dly (
    .clk   (rclk),
    .rst_n (arst_l),
    .d     ({bus.sctag_scbuf_evict_en_r0, bus.sctag_scbuf_ev_dword_r0}),
    .q     (ev_pipe_r3)
  );

  assign ev_vld_r3   = ev_pipe_r3[EV_DW_W];
  assign ev_dword_r3 = ev_pipe_r3[EV_DW_W-1:0];

  ev_state_e          state_q, state_d;
  logic [EV_DW_W-1:0] exp_q, exp_d;
  logic               acc_u_q, acc_u_d;
  logic               acc_c_q, acc_c_d;
  logic               seq_err_q, seq_err_d;
  logic [1:0]         ev_rpt_q, ev_rpt_d;
  logic [1:0]         ev_rpt_out;
  logic               cur_u, cur_c;

  assign cur_u = ev_vld_r3 & bus.ecc_ev_uerr_r3;
  assign cur_c = ev_vld_r3 & bus.ecc_ev_cerr_r3;

  // Evict FSM state, accumulators, sticky error and first report stage.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      acc_u_q   <= 1'b0;
      acc_c_q   <= 1'b0;
      seq_err_q <= 1'b0;
      ev_rpt_q  <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      acc_u_q   <= acc_u_d;
      acc_c_q   <= acc_c_d;
      seq_err_q <= seq_err_d;
      ev_rpt_q  <= ev_rpt_d;
    end
  end

  // Dword sequencing and error accumulation at r3; gaps hold state.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    acc_u_d   = acc_u_q;
    acc_c_d   = acc_c_q;
    seq_err_d = seq_err_q;
    ev_rpt_d  = '0;
    if (ev_vld_r3) begin
      unique case (state_q)
        IDLE: begin
          if (ev_dword_r3 == '0) begin
            state_d = ACCUM;
            exp_d   = EV_DW_W'(1);
            acc_u_d = cur_u;
            acc_c_d = cur_c;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        ACCUM: begin
          if (ev_dword_r3 == exp_q) begin
            if (exp_q == EV_LAST_DW) begin
              // Report and close in the same cycle so a dword 0 on the
              // very next r3 cycle starts a fresh eviction from IDLE.
              ev_rpt_d = err_resolve(acc_u_q | cur_u, acc_c_q | cur_c);
              state_d  = IDLE;
              exp_d    = '0;
              acc_u_d  = 1'b0;
              acc_c_d  = 1'b0;
            end else begin
              exp_d   = exp_q + EV_DW_W'(1);
              acc_u_d = acc_u_q | cur_u;
              acc_c_d = acc_c_q | cur_c;
            end
          end else begin
            seq_err_d = 1'b1;
            if (ev_dword_r3 == '0) begin
              state_d = ACCUM;
              exp_d   = EV_DW_W'(1);
              acc_u_d = cur_u;
              acc_c_d = cur_c;
            end else begin
              state_d = IDLE;
              exp_d   = '0;
              acc_u_d = 1'b0;
              acc_c_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  scbuf_err_dly #(.WIDTH(2), .DEPTH(EV_RPT_LAT - ECC_LAT - 1)) u_ev_rpt_dly (
    .clk   (rclk),
    .rst_n (arst_l),
    .d     (ev_rpt_q),
    .q     (ev_rpt_out)
  );

  assign bus.scbuf_sctag_ev_uerr_r5 = ev_rpt_out[1];
  assign bus.scbuf_sctag_ev_cerr_r5 = ev_rpt_out[0];
  assign bus.ev_seq_err             = seq_err_q;
  assign bus.ev_busy                = (state_q == ACCUM);

  // ---------------- RDMA stream ----------------
  logic [2:0] rd_pipe_r3;
  logic       rd_vld_r3;
  logic [1:0] rd_wl_r3;
  logic [1:0] rd_err_r3;
  logic [3:0] rd_rpt_r3;
  logic [3:0] rd_rpt_out;

  scbuf_err_dly #(.WIDTH(3), .DEPTH(ECC_LAT)) u_rd_r3_dly (
    .clk   (rclk),
    .rst_n (arst_l),
    .d     ({bus.sctag_scbuf_rdma_rden_r0, bus.sctag_scbuf_rdma_rdwl_r0}),
    .q     (rd_pipe_r3)
  );

  assign rd_vld_r3 = rd_pipe_r3[2];
  assign rd_wl_r3  = rd_pipe_r3[1:0];
  assign rd_err_r3 = err_resolve(rd_vld_r3 & bus.ecc_rdma_uerr_r3,
                                 rd_vld_r3 & bus.ecc_rdma_cerr_r3);
  assign rd_rpt_r3 = {rd_err_r3, (|rd_err_r3) ? rd_wl_r3 : 2'b00};

  scbuf_err_dly #(.WIDTH(4), .DEPTH(RDMA_RPT_LAT - ECC_LAT)) u_rd_rpt_dly (
    .clk   (rclk),
    .rst_n (arst_l),
    .d     (rd_rpt_r3),
    .q     (rd_rpt_out)
  );

  assign bus.scbuf_sctag_rdma_uerr_c10 = rd_rpt_out[3];
  assign bus.scbuf_sctag_rdma_cerr_c10 = rd_rpt_out[2];
  assign bus.scbuf_rdma_err_wl_c10     = rd_rpt_out[1:0];

endmodule
